uart_cmd_responder: RTL
=======================

// Module: uart_cmd_responder
// PURPOSE
//   Host-side command responder on the byte interface of the UART core.
//   - Consumes received bytes (RXbuffer/RXready) and parses framed read/write commands.
//   - Performs single-beat accesses on a simple register bus.
//   - Returns one reply byte per command through the UART transmitter (TXbuffer/TXstart/TXbusy).
// PARAMETERS
//   ADDR_WIDTH    8      bus address width; address byte zero-extended/truncated to fit
//   TIMEOUT       4096   CLK cycles allowed between bytes of one command before abort
//   READ_LATENCY  1      cycles from bus_re pulse to valid bus_rdata (>=1)
// PORTS
//   CLK        in   1           system clock; all logic on posedge CLK
//   RST        in   1           reset, asynchronous, active-high
//   RXbuffer   in   8           received byte from UART
//   RXready    in   1           one-cycle strobe: RXbuffer valid
//   TXbuffer   out  8           reply byte to UART transmitter
//   TXstart    out  1           one-cycle request to send TXbuffer
//   TXbusy     in   1           UART transmitter busy
//   bus_addr   out  ADDR_WIDTH  register address
//   bus_wdata  out  8           write data
//   bus_we     out  1           one-cycle write strobe
//   bus_re     out  1           one-cycle read strobe
//   bus_rdata  in   8           read data, valid READ_LATENCY cycles after bus_re
//   dropped    out  1           one-cycle pulse: RX byte discarded while busy replying
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, timeout counter=0; all outputs 0
//     (TXbuffer, TXstart, bus_addr, bus_wdata, bus_we, bus_re, dropped).
//   Protocol: 'W'(0x57) ADDR DATA -> bus write, reply 0x06 (ACK).
//             'R'(0x52) ADDR      -> bus read, reply = read data byte.
//             any other opcode    -> no bus access, reply 0x15 (NAK).
//   States:
//     IDLE      RXready: 0x57/0x52 -> GET_ADDR (latch op); else TXbuffer=0x15 -> TX_LOAD.
//     GET_ADDR  RXready: latch bus_addr; op W -> GET_DATA, op R -> RD_ISSUE.
//     GET_DATA  RXready: latch bus_wdata -> WR_ISSUE.
//     WR_ISSUE  bus_we=1 for 1 cycle; TXbuffer=0x06 -> TX_LOAD.
//     RD_ISSUE  bus_re=1 for 1 cycle -> RD_WAIT.
//     RD_WAIT   count READ_LATENCY cycles after the bus_re cycle; capture bus_rdata
//               into TXbuffer on the final cycle -> TX_LOAD.
//     TX_LOAD   if !TXbusy: TXstart=1 for exactly 1 cycle -> TX_WAIT_BUSY.
//     TX_WAIT_BUSY  wait for TXbusy=1 -> TX_WAIT_DONE.
//     TX_WAIT_DONE  wait for TXbusy=0 -> IDLE.
//   - Timeout: in GET_ADDR/GET_DATA the counter increments each cycle and clears on RXready.
//     On reaching TIMEOUT-1 -> IDLE with no bus access and no reply.
//     Counter is held at 0 in all other states.
//   - Latency: RXready of last command byte -> bus_we on the next cycle;
//     -> TXstart 2 cycles after RXready (write, TXbusy low).
//   - RX while busy: RXready in WR_ISSUE..TX_WAIT_DONE discards the byte and pulses
//     dropped the next cycle. No queuing.
//   - Simultaneous: RXready on the same cycle as a timeout expiry -> the byte wins and
//     parsing continues.
//   - TXbuffer holds its value until the next reply is loaded.
//   - bus_addr and bus_wdata hold their values between commands.
//   - TXstart is never asserted while TXbusy=1.
//   - At most one reply byte is outstanding at any time.
// TESTING
//   1. RX 0x57,0x10,0xA5 -> one bus_we with addr 0x10, wdata 0xA5; then TXstart with TXbuffer=0x06.
//   2. RX 0x52,0x22, bus_rdata=0x3C at latency 1 -> single bus_re at addr 0x22; reply TXbuffer=0x3C.
//   3. RX 0x41 -> no bus strobes; reply 0x15; return to IDLE after TXbusy falls.
//   4. RX 0x57,0x10 then silence TIMEOUT cycles -> no bus_we, no TXstart.
//      Next 0x52,0x10 parses normally.
//   5. RX byte during TX_WAIT_DONE -> dropped pulses once; no extra bus access or reply.
//   6. Assert RST in RD_WAIT and again mid-TX_WAIT_BUSY -> all outputs 0 immediately.
//      A full command then completes correctly.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses 'W' ADDR DATA / 'R' ADDR commands from the UART byte
// stream, performs one register-bus access and returns one reply byte.
`default_nettype none

module uart_cmd_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int TIMEOUT      = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RXbuffer,
    input  logic                  RXready,
    output logic [7:0]            TXbuffer,
    output logic                  TXstart,
    input  logic                  TXbusy,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [7:0]            bus_rdata,
    output logic                  dropped
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RL_W = $clog2(READ_LATENCY + 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

    // Ordered so that every state from WR_ISSUE upward is "busy replying".
    localparam logic [3:0] IDLE         = 4'd0;
    localparam logic [3:0] GET_ADDR     = 4'd1;
    localparam logic [3:0] GET_DATA     = 4'd2;
    localparam logic [3:0] WR_ISSUE     = 4'd3;
    localparam logic [3:0] RD_ISSUE     = 4'd4;
    localparam logic [3:0] RD_WAIT      = 4'd5;
    localparam logic [3:0] TX_LOAD      = 4'd6;
    localparam logic [3:0] TX_WAIT_BUSY = 4'd7;
    localparam logic [3:0] TX_WAIT_DONE = 4'd8;

    logic [3:0]            state_q, state_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [RL_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            txbuf_q, txbuf_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  dropped_q, dropped_d;
    logic [ADDR_WIDTH-1:0] addr_ext;

    generate
        if (ADDR_WIDTH > 8) begin : g_addr_wide
            assign addr_ext = {{(ADDR_WIDTH-8){1'b0}}, RXbuffer};
        end else if (ADDR_WIDTH == 8) begin : g_addr_exact
            assign addr_ext = RXbuffer;
        end else begin : g_addr_narrow
            assign addr_ext = RXbuffer[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        rd_cnt_d  = rd_cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txbuf_d   = txbuf_q;
        case (state_q)
            IDLE: begin
                if (RXready) begin
                    if (RXbuffer == OP_WRITE || RXbuffer == OP_READ) begin
                        op_wr_d = (RXbuffer == OP_WRITE);
                        state_d = GET_ADDR;
                    end else begin
                        txbuf_d = REPLY_NAK;
                        state_d = TX_LOAD;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // A byte arriving on the expiry cycle takes priority over the abort.
                if (RXready) begin
                    if (state_q == GET_ADDR) begin
                        addr_d  = addr_ext;
                        state_d = op_wr_q ? GET_DATA : RD_ISSUE;
                    end else begin
                        wdata_d = RXbuffer;
                        state_d = WR_ISSUE;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WR_ISSUE: begin
                txbuf_d = REPLY_ACK;
                state_d = TX_LOAD;
            end
            RD_ISSUE: begin
                rd_cnt_d = RL_W'(1);
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_cnt_q == RL_W'(READ_LATENCY)) begin
                    txbuf_d = bus_rdata;
                    state_d = TX_LOAD;
                end else begin
                    rd_cnt_d = rd_cnt_q + RL_W'(1);
                end
            end
            TX_LOAD:      if (!TXbusy) state_d = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (TXbusy)  state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!TXbusy) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
        // Issue states last exactly one cycle, so the strobes follow them directly.
        we_d      = (state_d == WR_ISSUE);
        re_d      = (state_d == RD_ISSUE);
        dropped_d = RXready && (state_q >= WR_ISSUE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            txbuf_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            txbuf_q   <= txbuf_d;
            we_q      <= we_d;
            re_q      <= re_d;
            dropped_q <= dropped_d;
        end
    end

    assign TXbuffer  = txbuf_q;
    assign TXstart   = (state_q == TX_LOAD) && !TXbusy;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;
    assign dropped   = dropped_q;

endmodule

`default_nettype wire
